// File: rtl/sw_cmd_queue.sv
// Toggle-framed PIO command decoder feeding a small valid/ready FIFO.
// Define SW_CMD_SYNC_EN to add a 2-flop synchronizer on sw_port.
module sw_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sw_port,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [2:0] hw_status
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [2:0]    port_q;
  logic          last_tog;
  logic          overflow;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [1:0]    mem [DEPTH];

`ifdef SW_CMD_SYNC_EN
  logic [2:0] sync_a;
  logic [2:0] sync_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= sw_port;
      sync_b <= sync_a;
    end
  end

  assign port_q = sync_b;
`else
  assign port_q = sw_port;
`endif

  logic evt;
  logic is_clr;
  logic push_req;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign evt      = port_q[2] != last_tog;
  assign is_clr   = port_q[1:0] == 2'b11;
  assign push_req = evt && !is_clr;
  assign full     = count == FULL_CNT;
  assign empty    = count == '0;
  assign pop      = !empty && cmd_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_tog <= 1'b0;
      overflow <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (evt)
        last_tog <= port_q[2];
      if (evt && is_clr)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= port_q[1:0];
  end

  assign cmd_valid = !empty;
  assign cmd_op    = mem[rd_ptr];
  assign hw_status = {overflow, full, last_tog};

endmodule

// File: tb/tb_sw_cmd_queue.sv
// Directed bench for sw_cmd_queue (default build, DEPTH=4).
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_sw_cmd_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] sw_port;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] hw_status;

  int passed = 0;
  int total  = 0;

  sw_cmd_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_port   (sw_port),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .hw_status (hw_status)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got=%h want=%h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input logic v,
                        input logic [2:0] st);
    chk({tag, "_valid"}, {3'b0, cmd_valid}, {3'b0, v});
    chk({tag, "_status"}, {1'b0, hw_status}, {1'b0, st});
  endtask

  initial begin
    reset_n   = 1'b0;
    sw_port   = 3'b000;
    cmd_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    chk_st("reset", 1'b0, 3'b000);
    repeat (20) step();
    chk_st("idle20", 1'b0, 3'b000);

    // single PAUSE command
    sw_port = 3'b101;
    step();
    chk_st("single", 1'b1, 3'b001);
    chk("single_op", {2'b0, cmd_op}, 4'h1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk_st("single_pop", 1'b0, 3'b001);

    // CLR on empty queue: consumed, never queued
    sw_port = 3'b011;
    step();
    chk_st("clr_empty", 1'b0, 3'b000);

    // fill and overflow
    sw_port = 3'b100; step();
    sw_port = 3'b001; step();
    sw_port = 3'b110; step();
    sw_port = 3'b000; step();
    chk_st("fill4", 1'b1, 3'b010);
    sw_port = 3'b101; step();
    chk_st("ovf", 1'b1, 3'b111);

    cmd_ready = 1'b1;
    chk("drain0", {2'b0, cmd_op}, 4'h0); step();
    chk("drain1", {2'b0, cmd_op}, 4'h1); step();
    chk("drain2", {2'b0, cmd_op}, 4'h2); step();
    chk("drain3", {2'b0, cmd_op}, 4'h0); step();
    chk_st("drained", 1'b0, 3'b101);
    cmd_ready = 1'b0;

    // refill to full with overflow still sticky
    sw_port = 3'b000; step();
    sw_port = 3'b101; step();
    sw_port = 3'b010; step();
    sw_port = 3'b100; step();
    chk_st("refill", 1'b1, 3'b111);

    sw_port = 3'b011;
    step();
    chk_st("clr_full", 1'b1, 3'b010);

    // push and pop while full
    chk("pp_head", {2'b0, cmd_op}, 4'h0);
    sw_port   = 3'b110;
    cmd_ready = 1'b1;
    step();
    chk_st("pushpop", 1'b1, 3'b011);
    chk("pp_d0", {2'b0, cmd_op}, 4'h1); step();
    chk("pp_d1", {2'b0, cmd_op}, 4'h2); step();
    chk("pp_d2", {2'b0, cmd_op}, 4'h0); step();
    chk("pp_d3", {2'b0, cmd_op}, 4'h2); step();
    chk_st("pp_empty", 1'b0, 3'b001);
    cmd_ready = 1'b0;

    // mid-operation reset
    sw_port = 3'b000; step();
    sw_port = 3'b101; step();
    sw_port = 3'b010; step();
    chk_st("three", 1'b1, 3'b000);
    reset_n = 1'b0;
    sw_port = 3'b000;
    step();
    reset_n = 1'b1;
    chk_st("midreset", 1'b0, 3'b000);
    step();
    chk_st("post_rst_idle", 1'b0, 3'b000);
    sw_port = 3'b110;
    step();
    chk_st("after_rst", 1'b1, 3'b001);
    chk("after_rst_op", {2'b0, cmd_op}, 4'h2);
    cmd_ready = 1'b1;
    step();
    chk_st("after_rst_pop", 1'b0, 3'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sw_cmd_queue.md
# sw_cmd_queue

Downstream consumer of the 3-bit software-to-hardware PIO port. Decodes toggle-framed command writes from the Nios II into a small command FIFO. Presents queued commands to game/control logic over a valid/ready handshake. Returns a 3-bit status word for the hardware-to-software PIO, so software can detect acceptance, backpressure and dropped commands.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16
- AW, 2: pointer width, log2(DEPTH)
- clk  in  1: system clock; all logic on rising edge
- reset_n  in  1: reset, synchronous, active-low
- sw_port  in  3: PIO data; [2] = command toggle, [1:0] = opcode
- cmd_ready  in  1: downstream accepts the head command
- cmd_valid  out  1: a queued command is at the head
- cmd_op  out  2: head opcode (00 START, 01 PAUSE, 10 RESTART)
- hw_status  out  3: {overflow, full, ack_toggle}; drives the hardware-to-software PIO

## Operation
- Framing: software writes a new opcode and flips bit 2 in the same PIO write. The block keeps `last_tog`. A new-command event is `sw_port[2] != last_tog`, evaluated on the port seen by the block.
- On an event:
  - `last_tog <= sw_port[2]` in every case.
  - Opcode 00/01/10: push to the FIFO.
  - Opcode 11 (CLR_STATUS): consumed internally, never queued; clears `overflow`.
- Push when full with no pop in the same cycle: the command is dropped, `overflow` is set (sticky), and `last_tog` still updates, so software never stalls waiting for ack.
- Pop occurs when `cmd_valid && cmd_ready`.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, the push is accepted (no overflow).
  - When empty, the pushed entry is not bypassed; `cmd_valid` rises next cycle.
- FIFO: DEPTH×2 storage, read/write pointers of AW bits that wrap modulo DEPTH, and an AW+1-bit count. `full = (count == DEPTH)`, `empty = (count == 0)`.
- `cmd_valid = !empty`. `cmd_op = mem[rd_ptr]`, which stays stable while `cmd_valid && !cmd_ready`.
- `hw_status = {overflow, full, last_tog}`. Software polls until bit 0 equals the toggle it wrote.
- Overflow clear and overflow set in the same cycle cannot collide, because only one event can occur per cycle.

## Timing
- Reset (reset_n low at a clock edge): `last_tog=0`, pointers=0, count=0, `overflow=0`. Consequently `cmd_valid=0` and `hw_status=3'b000`.
- Reset mid-operation discards all queued commands. This matches the PIO, which also resets its output to 0, so no spurious event follows reset.
- Event to `cmd_valid`: 1 cycle. A port change visible before edge N makes `cmd_valid` and `hw_status[0]` update after edge N.
- Back-to-back events on consecutive cycles are each accepted, one per cycle.
- Pop to the next head entry: `cmd_op` updates after the pop edge.
- `full` and `overflow` are registered-path outputs, valid the cycle after the causing edge.

## Configuration
- `SW_CMD_SYNC_EN` defined:
  - `sw_port` passes through a 2-flop synchronizer (reset to 0) before event detection, for a PIO in another clock domain.
  - Event-to-valid latency becomes 3 cycles.
  - Software must hold each write at least 3 cycles before the next toggle.
- Undefined: `sw_port` is used directly (same clock domain) with 1-cycle latency.

## Test plan
- Reset then idle: hold reset_n=0 for 2 cycles with sw_port=3'b000 -> after release, cmd_valid=0, hw_status=000, and nothing changes over 20 cycles.
- Single command: sw_port 000→101 (toggle=1, PAUSE) with cmd_ready=0 -> next cycle cmd_valid=1, cmd_op=01, hw_status=001. Raise cmd_ready for 1 cycle -> cmd_valid=0.
- Fill and overflow (DEPTH=4, cmd_ready=0):
  - Five toggled writes of opcodes 00,01,10,00,01 -> after the fourth, hw_status[1]=1. After the fifth, hw_status=111 (toggle=1).
  - Draining yields 00,01,10,00 in order; the fifth opcode (01) is absent.
- Full push+pop: with the FIFO full and cmd_ready=1, issue a toggle with opcode 10 -> count stays 4, overflow stays 0, and 10 emerges last.
- CLR_STATUS: after overflow, write opcode 11 with toggle -> hw_status[2]=0 next cycle, count unchanged, and no cmd_valid pulse from it.
- Mid-operation reset: with 3 entries queued, assert reset_n=0 for 1 cycle (sw_port also returned to 000) -> cmd_valid=0, hw_status=000. The next toggle is accepted as the first entry.
